mash_ddsm_gen: RTL and testbench
================================

Name: mash_ddsm_gen

Overview:
- Parametrised MASH 1-1-…-1 delta-sigma modulator for fractional-N division control. It succeeds the fixed four-stage error-feedback cascade.
- Runtime-selectable order 1..P_MAX_ORDER, configurable accumulator width and optional LFSR LSB dither.
- Built-in noise-cancellation network (NCN) producing a signed offset and a saturated integer divide value.
- Sits between the frequency-word register bank and the multi-modulus divider.

Parameters:
- P_DATA_WIDTH, 16: accumulator / fractional word width W.
- P_INT_WIDTH, 8: integer divide-word width.
- P_MAX_ORDER, 4: number of physical stages (1..4); offset width is P_MAX_ORDER+1.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset: asynchronous assert, active-low.
- i_en  in  1  advance modulator one step.
- i_load  in  1  one-cycle strobe; latches i_frac, i_int, i_order, i_dither_en into shadow registers.
- i_frac  in  P_DATA_WIDTH  fractional word.
- i_int  in  P_INT_WIDTH  integer word.
- i_order  in  3  requested order; clamped to [1,P_MAX_ORDER]; 0 treated as 1.
- i_dither_en  in  1  add LFSR bit to stage-1 LSB.
- o_valid  out  1  o_offset/o_div valid.
- o_offset  out  P_MAX_ORDER+1  signed NCN output d1.
- o_div  out  P_INT_WIDTH  i_int + d1, saturated.
- o_sat  out  1  o_div clamped this sample.

Behaviour:
- Reset: all accumulators, NCN delay registers, shadow registers, o_offset, o_div, o_valid and o_sat = 0. Shadow order = 1, LFSR = 15'h0001.
- Shadow load:
  - i_load is sampled every cycle regardless of i_en; shadow values apply from the next cycle.
  - If the newly loaded order differs from the current order, all accumulators and NCN registers clear in that same clock edge. i_en has no effect on that edge.
- Stages, per enabled cycle, combinational through the chain:
  - Stage-1 input u1 = frac + (dither_en ? lfsr[0] : 0).
  - Stage k>1 input uk = next-state sum of stage k-1.
  - sum_k = acc_k + uk mod 2^W; c_k = carry out. acc_k <= sum_k.
  - Stages k > order: acc held 0, c_k forced 0.
- NCN (signed, width P_MAX_ORDER+1):
  - d_order = c_order.
  - For k = order-1 down to 1: d_k = c_k + d_{k+1} - r_{k+1}, where r_{k+1} is d_{k+1} registered on the previous enabled cycle.
  - Registers r_k update only when i_en = 1.
  - d1 range: [-(2^(order-1)-1), 2^(order-1)].
- Output stage (registered, latency 1 cycle from the enabled sample):
  - o_offset <= d1.
  - Signed sum s = i_int(shadow) + d1.
  - If s < 0: o_div = 0, o_sat = 1. If s > 2^P_INT_WIDTH-1: o_div = all-ones, o_sat = 1. Otherwise o_div = s, o_sat = 0.
  - o_valid <= i_en.
  - When i_en = 0: all state is held, o_valid = 0, and o_offset/o_div/o_sat keep their last values.
- LFSR: 15-bit Fibonacci, taps x^15+x^14+1; shifts only on enabled cycles, independent of dither_en.
- Simultaneous i_load and i_en: that cycle's step uses the old shadow values; the new values apply from the next cycle.
- Reset asserted mid-operation: immediate clear to the reset values listed above. The first valid output occurs 1 cycle after the first enabled cycle following deassertion.

Test Plan:
- Order 1, W=16, frac=16'h4000, int=10, dither off, en continuous: o_offset pattern repeats 0,0,0,1 (carry on every 4th step); o_div alternates 10/11; exactly 16384 ones in 65536 samples.
- Order 4, frac=0, dither off: o_offset = 0 and o_div = int for all samples; o_sat = 0.
- Order 3, frac=16'h8001, 4096 samples: every o_offset in [-3,4]; |sum(o_offset) - 4096·frac/2^16| ≤ 4.
- Order 2, int=0, frac=16'h0100: at least one o_offset = -1 occurs, with o_div = 0 and o_sat = 1 on that sample. Repeat with int=255: o_div is never above 255, and o_sat flags every o_offset > 0.
- Order change 3→1 via i_load mid-run: accumulators read 0 the next cycle; o_offset ∈ {0,1} thereafter. Reloading the same order does not clear state.
- Assert i_rst_n low for 1 cycle mid-stream: all outputs 0 immediately, LFSR = 1. With i_en low for 5 cycles: outputs frozen, o_valid = 0, sequence resumes unchanged.

Source files
------------

// File: rtl/mash_ddsm_gen.sv
// -----------------------------------------------------------------------------
// mash_ddsm_gen
// Parametrised MASH 1-1-...-1 delta-sigma modulator for fractional-N divider
// control. Runtime order 1..P_MAX_ORDER, optional LFSR dither on the stage-1
// LSB, built-in noise-cancellation network and a saturated integer divide
// value for the multi-modulus divider.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_en         advance the modulator one step
//   i_load       one-cycle strobe, latches i_frac/i_int/i_order/i_dither_en
//   i_frac       fractional word (P_DATA_WIDTH)
//   i_int        integer divide word (P_INT_WIDTH)
//   i_order      requested order, clamped to [1, P_MAX_ORDER]
//   i_dither_en  add LFSR bit to the stage-1 LSB
//   o_valid      o_offset/o_div hold a fresh sample
//   o_offset     signed NCN output d1 (P_MAX_ORDER+1 bits)
//   o_div        i_int + d1, saturated to [0, 2^P_INT_WIDTH-1]
//   o_sat        o_div was clamped on this sample
// -----------------------------------------------------------------------------
module mash_ddsm_gen #(
   parameter int P_DATA_WIDTH = 16,
   parameter int P_INT_WIDTH  = 8,
   parameter int P_MAX_ORDER  = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_en,
   input  logic                          i_load,
   input  logic [P_DATA_WIDTH-1:0]       i_frac,
   input  logic [P_INT_WIDTH-1:0]        i_int,
   input  logic [2:0]                    i_order,
   input  logic                          i_dither_en,
   output logic                          o_valid,
   output logic signed [P_MAX_ORDER:0]   o_offset,
   output logic [P_INT_WIDTH-1:0]        o_div,
   output logic                          o_sat
);

   localparam int         OW          = P_MAX_ORDER + 1;
   localparam int         SW          = P_INT_WIDTH + 2;
   localparam logic [2:0] MAX_ORDER_L = 3'(P_MAX_ORDER);

   // shadow configuration
   logic [P_DATA_WIDTH-1:0] frac_r;
   logic [P_INT_WIDTH-1:0]  int_r;
   logic [2:0]              order_r;
   logic                    dither_r;

   // modulator state
   logic [14:0]             lfsr_r;
   logic [P_DATA_WIDTH-1:0] acc_r [P_MAX_ORDER];
   logic signed [OW-1:0]    ncn_r [P_MAX_ORDER];

   // combinational chain
   logic [2:0]              req_order_s;
   logic                    order_chg_s;
   logic                    step_s;
   logic                    dither_bit_s;
   logic [P_DATA_WIDTH-1:0] acc_nxt_s [P_MAX_ORDER];
   logic                    carry_s   [P_MAX_ORDER];
   logic signed [OW-1:0]    d_s       [P_MAX_ORDER];
   logic signed [SW-1:0]    div_sum_s;
   logic [P_INT_WIDTH-1:0]  div_nxt_s;
   logic                    sat_nxt_s;

   // A load that changes the effective order wipes the cascade and
   // suppresses the step on that edge so no mixed-order sample escapes.
   assign order_chg_s  = i_load && (req_order_s != order_r);
   assign step_s       = i_en && !order_chg_s;
   assign dither_bit_s = dither_r & lfsr_r[0];

   // Clamp the requested order into the physically available range.
   always_comb begin
      req_order_s = 3'd1;
      if (i_order == 3'd0) begin
         req_order_s = 3'd1;
      end else if (i_order > MAX_ORDER_L) begin
         req_order_s = MAX_ORDER_L;
      end else begin
         req_order_s = i_order;
      end
   end

   // Accumulator cascade: each stage integrates the next-state sum of the
   // previous one; stages above the active order are parked at zero.
   always_comb begin
      logic [P_DATA_WIDTH:0]   sum_v;
      logic [P_DATA_WIDTH-1:0] u_v;
      logic                    cin_v;
      sum_v = {(P_DATA_WIDTH+1){1'b0}};
      u_v   = frac_r;
      cin_v = dither_bit_s;
      for (int k = 0; k < P_MAX_ORDER; k++) begin
         sum_v = {1'b0, acc_r[k]} + {1'b0, u_v} + {{P_DATA_WIDTH{1'b0}}, cin_v};
         if (k < int'(order_r)) begin
            acc_nxt_s[k] = sum_v[P_DATA_WIDTH-1:0];
            carry_s[k]   = sum_v[P_DATA_WIDTH];
         end else begin
            acc_nxt_s[k] = {P_DATA_WIDTH{1'b0}};
            carry_s[k]   = 1'b0;
         end
         u_v   = acc_nxt_s[k];
         cin_v = 1'b0;
      end
   end

   // Noise-cancellation network, evaluated from the top active stage down:
   // d_k = c_k + d_{k+1} - r_{k+1} (first difference of the stage above).
   always_comb begin
      logic signed [OW-1:0] d_up_v;
      logic signed [OW-1:0] r_up_v;
      d_up_v = {OW{1'b0}};
      r_up_v = {OW{1'b0}};
      for (int k = P_MAX_ORDER - 1; k >= 0; k--) begin
         if (k >= int'(order_r)) begin
            d_s[k] = {OW{1'b0}};
         end else if (k == int'(order_r) - 1) begin
            d_s[k] = $signed({{(OW-1){1'b0}}, carry_s[k]});
         end else begin
            d_s[k] = $signed({{(OW-1){1'b0}}, carry_s[k]}) + d_up_v - r_up_v;
         end
         d_up_v = d_s[k];
         r_up_v = ncn_r[k];
      end
   end

   // Integer plus offset with clamping to the unsigned divide-word range.
   always_comb begin
      div_sum_s = $signed({2'b00, int_r}) + SW'(d_s[0]);
      div_nxt_s = {P_INT_WIDTH{1'b0}};
      sat_nxt_s = 1'b0;
      if (div_sum_s[SW-1]) begin
         div_nxt_s = {P_INT_WIDTH{1'b0}};
         sat_nxt_s = 1'b1;
      end else if (div_sum_s[SW-2]) begin
         div_nxt_s = {P_INT_WIDTH{1'b1}};
         sat_nxt_s = 1'b1;
      end else begin
         div_nxt_s = div_sum_s[P_INT_WIDTH-1:0];
         sat_nxt_s = 1'b0;
      end
   end

   // Shadow configuration registers, sampled on every load strobe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         frac_r   <= {P_DATA_WIDTH{1'b0}};
         int_r    <= {P_INT_WIDTH{1'b0}};
         order_r  <= 3'd1;
         dither_r <= 1'b0;
      end else if (i_load) begin
         frac_r   <= i_frac;
         int_r    <= i_int;
         order_r  <= req_order_s;
         dither_r <= i_dither_en;
      end else begin
         frac_r   <= frac_r;
         int_r    <= int_r;
         order_r  <= order_r;
         dither_r <= dither_r;
      end
   end

   // Accumulators, NCN delay registers and dither LFSR.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lfsr_r <= 15'h0001;
         for (int k = 0; k < P_MAX_ORDER; k++) begin
            acc_r[k] <= {P_DATA_WIDTH{1'b0}};
            ncn_r[k] <= {OW{1'b0}};
         end
      end else if (order_chg_s) begin
         lfsr_r <= lfsr_r;
         for (int k = 0; k < P_MAX_ORDER; k++) begin
            acc_r[k] <= {P_DATA_WIDTH{1'b0}};
            ncn_r[k] <= {OW{1'b0}};
         end
      end else if (step_s) begin
         lfsr_r <= {lfsr_r[13:0], lfsr_r[14] ^ lfsr_r[13]};
         for (int k = 0; k < P_MAX_ORDER; k++) begin
            acc_r[k] <= acc_nxt_s[k];
            ncn_r[k] <= d_s[k];
         end
      end else begin
         lfsr_r <= lfsr_r;
         for (int k = 0; k < P_MAX_ORDER; k++) begin
            acc_r[k] <= acc_r[k];
            ncn_r[k] <= ncn_r[k];
         end
      end
   end

   // Registered outputs; data outputs hold their last sample when idle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid  <= 1'b0;
         o_offset <= {OW{1'b0}};
         o_div    <= {P_INT_WIDTH{1'b0}};
         o_sat    <= 1'b0;
      end else if (step_s) begin
         o_valid  <= 1'b1;
         o_offset <= d_s[0];
         o_div    <= div_nxt_s;
         o_sat    <= sat_nxt_s;
      end else begin
         o_valid  <= 1'b0;
         o_offset <= o_offset;
         o_div    <= o_div;
         o_sat    <= o_sat;
      end
   end

endmodule

// File: tb/tb_mash_ddsm_gen.sv
// -----------------------------------------------------------------------------
// tb_mash_ddsm_gen
// Self-checking bench for mash_ddsm_gen: a table of per-cycle vectors with
// hand-derived outputs, followed by long-run sequences for order 4 with a
// zero word, order-1 density, order-3 range/mean, and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_mash_ddsm_gen;

   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic              i_en;
   logic              i_load;
   logic [15:0]       i_frac;
   logic [7:0]        i_int;
   logic [2:0]        i_order;
   logic              i_dither_en;
   logic              o_valid;
   logic signed [4:0] o_offset;
   logic [7:0]        o_div;
   logic              o_sat;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic        ld;
      logic [15:0] frac;
      logic [7:0]  iw;
      logic [2:0]  ord;
      logic        en;
      logic        ev;
      int          eoff;
      int          ediv;
      logic        esat;
      logic        clr;
   } vec_t;

   vec_t vecs[$];

   mash_ddsm_gen #(
      .P_DATA_WIDTH(16),
      .P_INT_WIDTH (8),
      .P_MAX_ORDER (4)
   ) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (i_en),
      .i_load     (i_load),
      .i_frac     (i_frac),
      .i_int      (i_int),
      .i_order    (i_order),
      .i_dither_en(i_dither_en),
      .o_valid    (o_valid),
      .o_offset   (o_offset),
      .o_div      (o_div),
      .o_sat      (o_sat)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic ld, input logic [15:0] frac, input logic [7:0] iw,
                      input logic [2:0] ord, input logic en, input logic ev,
                      input int eoff, input int ediv, input logic esat, input logic clr);
      vec_t v;
      v.ld = ld; v.frac = frac; v.iw = iw; v.ord = ord; v.en = en;
      v.ev = ev; v.eoff = eoff; v.ediv = ediv; v.esat = esat; v.clr = clr;
      vecs.push_back(v);
   endtask

   // Apply one cycle of inputs and return #1 after the capturing edge.
   task automatic drive(input logic ld, input logic [15:0] f, input logic [7:0] iw,
                        input logic [2:0] o, input logic en);
      i_load  = ld;
      i_frac  = f;
      i_int   = iw;
      i_order = o;
      i_en    = en;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      int ones;
      int sum;
      int off;
      int any_acc;

      i_rst_n = 1'b0; i_en = 1'b0; i_load = 1'b0; i_frac = 16'h0000;
      i_int = 8'd0; i_order = 3'd0; i_dither_en = 1'b0;

      // ---------------- vector table ----------------
      // order 1, frac = 1/4, int 10: carry every 4th step
      add(1'b1, 16'h4000, 8'd10, 3'd1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      for (int s = 1; s <= 8; s++)
         add(1'b0, 16'h4000, 8'd10, 3'd1, 1'b1, 1'b1,
             (s % 4 == 0) ? 1 : 0, (s % 4 == 0) ? 11 : 10, 1'b0, 1'b0);
      // i_en low: frozen outputs, then resume unchanged
      add(1'b0, 16'h4000, 8'd10, 3'd1, 1'b0, 1'b0, 1, 11, 1'b0, 1'b0);
      add(1'b0, 16'h4000, 8'd10, 3'd1, 1'b0, 1'b0, 1, 11, 1'b0, 1'b0);
      add(1'b0, 16'h4000, 8'd10, 3'd1, 1'b1, 1'b1, 0, 10, 1'b0, 1'b0);
      // load with en: order 0 clamps to 1 (no clear), step uses old int
      add(1'b1, 16'h4000, 8'd20, 3'd0, 1'b1, 1'b1, 0, 10, 1'b0, 1'b0);
      add(1'b0, 16'h4000, 8'd20, 3'd0, 1'b1, 1'b1, 0, 20, 1'b0, 1'b0);
      add(1'b0, 16'h4000, 8'd20, 3'd0, 1'b1, 1'b1, 1, 21, 1'b0, 1'b0);
      // order 2, frac 1/16, int 0: order change suppresses the step
      add(1'b1, 16'h1000, 8'd0, 3'd2, 1'b1, 1'b0, 1, 21, 1'b0, 1'b0);
      for (int s = 1; s <= 5; s++)
         add(1'b0, 16'h1000, 8'd0, 3'd2, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
      add(1'b0, 16'h1000, 8'd0, 3'd2, 1'b1, 1'b1, 1, 1, 1'b0, 1'b0);
      add(1'b0, 16'h1000, 8'd0, 3'd2, 1'b1, 1'b1, -1, 0, 1'b1, 1'b0);
      // same stream with int 255 after restart through order 1
      add(1'b1, 16'h1000, 8'd255, 3'd1, 1'b0, 1'b0, -1, 0, 1'b1, 1'b0);
      add(1'b1, 16'h1000, 8'd255, 3'd2, 1'b0, 1'b0, -1, 0, 1'b1, 1'b0);
      for (int s = 1; s <= 5; s++)
         add(1'b0, 16'h1000, 8'd255, 3'd2, 1'b1, 1'b1, 0, 255, 1'b0, 1'b0);
      add(1'b0, 16'h1000, 8'd255, 3'd2, 1'b1, 1'b1, 1, 255, 1'b1, 1'b0);
      add(1'b0, 16'h1000, 8'd255, 3'd2, 1'b1, 1'b1, -1, 254, 1'b0, 1'b0);
      // order 3 frac 1/4, then switch to order 1 mid-run
      add(1'b1, 16'h4000, 8'd10, 3'd3, 1'b0, 1'b0, -1, 254, 1'b0, 1'b0);
      add(1'b0, 16'h4000, 8'd10, 3'd3, 1'b1, 1'b1, 0, 10, 1'b0, 1'b0);
      add(1'b0, 16'h4000, 8'd10, 3'd3, 1'b1, 1'b1, 1, 11, 1'b0, 1'b0);
      add(1'b0, 16'h4000, 8'd10, 3'd3, 1'b1, 1'b1, -1, 9, 1'b0, 1'b0);
      add(1'b1, 16'h4000, 8'd10, 3'd1, 1'b1, 1'b0, -1, 9, 1'b0, 1'b1);
      for (int s = 1; s <= 4; s++)
         add(1'b0, 16'h4000, 8'd10, 3'd1, 1'b1, 1'b1,
             (s == 4) ? 1 : 0, (s == 4) ? 11 : 10, 1'b0, 1'b0);

      // ---------------- reset state ----------------
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      chk("rst.valid",  int'(o_valid), 0);
      chk("rst.offset", int'(o_offset), 0);
      chk("rst.div",    int'(o_div), 0);
      chk("rst.sat",    int'(o_sat), 0);
      chk("rst.lfsr",   int'(dut.lfsr_r), 1);

      // ---------------- table run ----------------
      foreach (vecs[i]) begin
         drive(vecs[i].ld, vecs[i].frac, vecs[i].iw, vecs[i].ord, vecs[i].en);
         chk($sformatf("v%0d.valid", i),  int'(o_valid), int'(vecs[i].ev));
         chk($sformatf("v%0d.offset", i), int'(o_offset), vecs[i].eoff);
         chk($sformatf("v%0d.div", i),    int'(o_div), vecs[i].ediv);
         chk($sformatf("v%0d.sat", i),    int'(o_sat), int'(vecs[i].esat));
         if (vecs[i].clr) begin
            any_acc = 0;
            for (int k = 0; k < 4; k++)
               if (dut.acc_r[k] != 16'h0000) any_acc = 1;
            chk($sformatf("v%0d.acc_clear", i), any_acc, 0);
         end
      end

      // ---------------- order 4 (request 7 clamps), frac 0 ----------------
      drive(1'b1, 16'h0000, 8'd77, 3'd7, 1'b0);
      for (int s = 0; s < 64; s++) begin
         drive(1'b0, 16'h0000, 8'd77, 3'd7, 1'b1);
         chk("o4.offset", int'(o_offset), 0);
         chk("o4.div",    int'(o_div), 77);
         chk("o4.sat",    int'(o_sat), 0);
      end

      // ---------------- order 1 density ----------------
      drive(1'b1, 16'h4000, 8'd10, 3'd1, 1'b0);
      ones = 0;
      for (int s = 0; s < 4096; s++) begin
         drive(1'b0, 16'h4000, 8'd10, 3'd1, 1'b1);
         off = o_offset;
         if (off == 1) ones++;
         chk("o1.div", int'(o_div), 10 + off);
      end
      chk("o1.ones", ones, 1024);

      // ---------------- order 3, frac 0x8001 ----------------
      drive(1'b1, 16'h8001, 8'd100, 3'd3, 1'b0);
      sum = 0;
      for (int s = 0; s < 4096; s++) begin
         drive(1'b0, 16'h8001, 8'd100, 3'd3, 1'b1);
         off = o_offset;
         sum += off;
         chk("o3.range", int'(off >= -3 && off <= 4), 1);
         chk("o3.div", int'(o_div), 100 + off);
      end
      chk("o3.mean_within4", int'((sum - 2048) >= -4 && (sum - 2048) <= 4), 1);

      // ---------------- mid-stream reset ----------------
      drive(1'b0, 16'h8001, 8'd100, 3'd3, 1'b1);
      i_rst_n = 1'b0;
      i_en    = 1'b0;
      #1;
      chk("mrst.valid",  int'(o_valid), 0);
      chk("mrst.offset", int'(o_offset), 0);
      chk("mrst.div",    int'(o_div), 0);
      chk("mrst.sat",    int'(o_sat), 0);
      chk("mrst.lfsr",   int'(dut.lfsr_r), 1);
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      drive(1'b0, 16'h0000, 8'd0, 3'd0, 1'b0);
      chk("post.idle_valid", int'(o_valid), 0);
      drive(1'b0, 16'h0000, 8'd0, 3'd0, 1'b1);
      chk("post.valid",  int'(o_valid), 1);
      chk("post.offset", int'(o_offset), 0);
      chk("post.div",    int'(o_div), 0);
      // 14 more steps: 15 total from seed 0x0001
      for (int s = 0; s < 14; s++) drive(1'b0, 16'h0000, 8'd0, 3'd0, 1'b1);
      chk("post.lfsr15", int'(dut.lfsr_r), 3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
